// File: rtl/sync_fifo_flags_pkg.sv
// sync_fifo_flags_pkg: shared FWFT mode constants, count width and threshold legality check
package sync_fifo_flags_pkg;

    localparam bit FWFT_OFF = 1'b0;
    localparam bit FWFT_ON  = 1'b1;

    // Count must hold 0..depth inclusive, hence one bit more than the address
    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit threshOk(input int depth, input int aFull, input int aEmpty);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) && (aEmpty < aFull) && (aFull <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: one write port, registered read (EBR style) or combinational read (FWFT)
module sync_fifo_mem
    import sync_fifo_flags_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter bit FWFT       = FWFT_OFF,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iWrEn,
    input  logic [AW-1:0]         iWrAddr,
    input  logic [DATA_WIDTH-1:0] iWrData,
    input  logic                  iRdEn,
    input  logic [AW-1:0]         iRdAddr,
    output logic [DATA_WIDTH-1:0] oRdData
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Storage array carries no reset so it can map onto block or LUT RAM
    always_ff @(posedge iClk) begin
        if (iWrEn) mem[iWrAddr] <= iWrData;
    end

    if (FWFT == FWFT_ON) begin : gAsyncRd
        logic unusedRd;
        assign unusedRd = iRdEn & iRstN;
        assign oRdData  = mem[iRdAddr];
    end else begin : gSyncRd
        logic [DATA_WIDTH-1:0] rdDataQ;
        // Output register loads only on a popped word and otherwise holds its value
        always_ff @(posedge iClk or negedge iRstN) begin
            if (!iRstN)     rdDataQ <= '0;
            else if (iRdEn) rdDataQ <= mem[iRdAddr];
        end
        assign oRdData = rdDataQ;
    end

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with registered count, threshold flags, sticky errors and optional FWFT
module sync_fifo_flags
    import sync_fifo_flags_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter bit FWFT          = FWFT_OFF,
    localparam int CW           = countWidth(FIFO_DEPTH)
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iClr,
    input  logic                  iWrEn,
    input  logic [DATA_WIDTH-1:0] iWrData,
    output logic                  oFull,
    output logic                  oAlmostFull,
    output logic                  oOverflow,
    input  logic                  iRdEn,
    output logic [DATA_WIDTH-1:0] oRdData,
    output logic                  oRdValid,
    output logic                  oEmpty,
    output logic                  oAlmostEmpty,
    output logic                  oUnderflow,
    output logic [CW-1:0]         oCount
);

    localparam int AW = $clog2(FIFO_DEPTH);

    if (!threshOk(FIFO_DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : gBadParams
        $error("sync_fifo_flags: illegal depth or threshold parameters");
    end

    logic [AW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count;
    logic          overflowQ, underflowQ, rdValidQ;
    logic          wrAcc, rdAcc;

    // Acceptance uses registered flags so a full FIFO still takes a read and an empty one a write
    always_comb begin
        wrAcc = iWrEn & ~oFull;
        rdAcc = iRdEn & ~oEmpty;
    end

    // Pointers, occupancy and sticky errors; clear overrides any traffic that cycle
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            overflowQ  <= 1'b0;
            underflowQ <= 1'b0;
            rdValidQ   <= 1'b0;
        end else if (iClr) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            overflowQ  <= 1'b0;
            underflowQ <= 1'b0;
            rdValidQ   <= 1'b0;
        end else begin
            if (wrAcc) wrPtr <= wrPtr + AW'(1);
            if (rdAcc) rdPtr <= rdPtr + AW'(1);
            if (wrAcc & ~rdAcc)      count <= count + CW'(1);
            else if (rdAcc & ~wrAcc) count <= count - CW'(1);
            overflowQ  <= overflowQ | (iWrEn & oFull);
            underflowQ <= underflowQ | (iRdEn & oEmpty);
            rdValidQ   <= rdAcc;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .FWFT      (FWFT)
    ) uMem (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iWrEn  (wrAcc & ~iClr),
        .iWrAddr(wrPtr),
        .iWrData(iWrData),
        .iRdEn  (rdAcc & ~iClr),
        .iRdAddr(rdPtr),
        .oRdData(oRdData)
    );

    // Status flags decode from the registered count only
    always_comb begin
        oCount       = count;
        oFull        = count == CW'(FIFO_DEPTH);
        oEmpty       = count == '0;
        oAlmostFull  = count >= CW'(AFULL_THRESH);
        oAlmostEmpty = count <= CW'(AEMPTY_THRESH);
        oOverflow    = overflowQ;
        oUnderflow   = underflowQ;
        oRdValid     = (FWFT == FWFT_ON) ? ~oEmpty : rdValidQ;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed checks of a standard-read and an FWFT instance
module tb_sync_fifo_flags;

    logic       iClk = 1'b0;
    logic       iRstN;
    logic       clr0, wrEn0, rdEn0;
    logic [7:0] wrData0;
    logic       full0, aFull0, ovf0, rdValid0, empty0, aEmpty0, udf0;
    logic [7:0] rdData0;
    logic [4:0] count0;
    logic       clr1, wrEn1, rdEn1;
    logic [7:0] wrData1;
    logic       full1, aFull1, ovf1, rdValid1, empty1, aEmpty1, udf1;
    logic [7:0] rdData1;
    logic [4:0] count1;
    int         nTests = 0;
    int         nFail  = 0;
    logic [7:0] q[$];
    logic [7:0] expData;

    always #5 iClk = ~iClk;

    sync_fifo_flags #(.FWFT(1'b0)) dut0 (
        .iClk(iClk), .iRstN(iRstN), .iClr(clr0), .iWrEn(wrEn0), .iWrData(wrData0),
        .oFull(full0), .oAlmostFull(aFull0), .oOverflow(ovf0), .iRdEn(rdEn0),
        .oRdData(rdData0), .oRdValid(rdValid0), .oEmpty(empty0), .oAlmostEmpty(aEmpty0),
        .oUnderflow(udf0), .oCount(count0)
    );

    sync_fifo_flags #(.FWFT(1'b1)) dut1 (
        .iClk(iClk), .iRstN(iRstN), .iClr(clr1), .iWrEn(wrEn1), .iWrData(wrData1),
        .oFull(full1), .oAlmostFull(aFull1), .oOverflow(ovf1), .iRdEn(rdEn1),
        .oRdData(rdData1), .oRdValid(rdValid1), .oEmpty(empty1), .oAlmostEmpty(aEmpty1),
        .oUnderflow(udf1), .oCount(count1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    initial begin
        iRstN = 1'b0;
        {clr0, wrEn0, rdEn0, clr1, wrEn1, rdEn1} = '0;
        wrData0 = '0;
        wrData1 = '0;
        #3;
        check("rst count", count0, 0);
        check("rst empty", empty0, 1);
        check("rst aempty", aEmpty0, 1);
        check("rst full", full0, 0);
        check("rst afull", aFull0, 0);
        check("rst ovf", ovf0, 0);
        check("rst udf", udf0, 0);
        check("rst rdvalid", rdValid0, 0);
        check("rst rddata", rdData0, 0);
        check("rst fwft rdvalid", rdValid1, 0);
        @(negedge iClk);
        iRstN = 1'b1;

        for (int i = 1; i <= 16; i++) begin
            wrEn0 = 1'b1;
            wrData0 = 8'(i);
            step();
            check("fill count", count0, i);
            check("fill empty", empty0, 0);
            check("fill afull", aFull0, (i >= 14) ? 1 : 0);
            check("fill aempty", aEmpty0, (i <= 2) ? 1 : 0);
        end
        wrEn0 = 1'b0;
        check("full flag", full0, 1);

        wrEn0 = 1'b1;
        wrData0 = 8'hAA;
        step();
        wrEn0 = 1'b0;
        check("ovf set", ovf0, 1);
        check("ovf count", count0, 16);
        step();
        check("ovf sticky", ovf0, 1);

        for (int i = 1; i <= 16; i++) begin
            rdEn0 = 1'b1;
            step();
            check("drain valid", rdValid0, 1);
            check("drain data", rdData0, i);
            check("drain count", count0, 16 - i);
        end
        rdEn0 = 1'b0;
        step();
        check("idle valid", rdValid0, 0);
        check("idle empty", empty0, 1);
        check("hold data", rdData0, 8'h10);

        rdEn0 = 1'b1;
        step();
        rdEn0 = 1'b0;
        check("udf set", udf0, 1);
        check("udf valid", rdValid0, 0);
        check("udf count", count0, 0);
        check("udf hold data", rdData0, 8'h10);
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        check("clr ovf", ovf0, 0);
        check("clr udf", udf0, 0);

        for (int i = 0; i < 8; i++) begin
            wrEn0 = 1'b1;
            wrData0 = 8'h20 + 8'(i);
            q.push_back(wrData0);
            step();
        end
        check("half count", count0, 8);
        for (int k = 0; k < 20; k++) begin
            wrEn0 = 1'b1;
            rdEn0 = 1'b1;
            wrData0 = 8'h28 + 8'(k);
            q.push_back(wrData0);
            step();
            expData = q.pop_front();
            check("stream count", count0, 8);
            check("stream data", rdData0, expData);
            check("stream valid", rdValid0, 1);
        end
        wrEn0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            expData = q.pop_front();
            check("pre-rst data", rdData0, expData);
        end
        rdEn0 = 1'b0;
        check("pre-rst count", count0, 5);
        #2;
        iRstN = 1'b0;
        #1;
        check("async rst count", count0, 0);
        check("async rst empty", empty0, 1);
        check("async rst valid", rdValid0, 0);
        check("async rst data", rdData0, 0);
        check("async rst aempty", aEmpty0, 1);
        @(negedge iClk);
        iRstN = 1'b1;

        wrEn0 = 1'b1;
        wrData0 = 8'h11;
        step();
        step();
        check("pre-clr count", count0, 2);
        clr0 = 1'b1;
        wrData0 = 8'h77;
        step();
        clr0 = 1'b0;
        wrEn0 = 1'b0;
        check("clr+wr count", count0, 0);
        check("clr+wr empty", empty0, 1);

        wrEn1 = 1'b1;
        wrData1 = 8'h5C;
        step();
        wrData1 = 8'h5D;
        check("fwft data", rdData1, 8'h5C);
        check("fwft valid", rdValid1, 1);
        check("fwft empty", empty1, 0);
        step();
        wrEn1 = 1'b0;
        check("fwft head held", rdData1, 8'h5C);
        rdEn1 = 1'b1;
        step();
        check("fwft pop data", rdData1, 8'h5D);
        check("fwft pop count", count1, 1);
        step();
        rdEn1 = 1'b0;
        check("fwft drained", empty1, 1);
        check("fwft invalid", rdValid1, 0);
        check("fwft no udf", udf1, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO with registered count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous clear and a selectable first-word-fall-through read mode. It is the general-purpose buffer between producer and consumer stages in the iClk domain, e.g. UART/SPI byte streams and sample pipelines on the iCE40UP5K.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- FIFO_DEPTH, 16, entries; power of two, ≥2
- AFULL_THRESH, FIFO_DEPTH-2, oAlmostFull asserted when count ≥ this value
- AEMPTY_THRESH, 2, oAlmostEmpty asserted when count ≤ this value; requires AEMPTY_THRESH < AFULL_THRESH ≤ FIFO_DEPTH
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- CW (localparam), $clog2(FIFO_DEPTH)+1, count width

Ports (reset is iRstN, asynchronous, active-low; clock is iClk):
- iClk  in  1  clock, rising-edge
- iRstN  in  1  asynchronous active-low reset
- iClr  in  1  synchronous clear of pointers, count and error flags
- iWrEn  in  1  write request
- iWrData  in  DATA_WIDTH  write data
- oFull  out  1  count == FIFO_DEPTH
- oAlmostFull  out  1  count ≥ AFULL_THRESH
- oOverflow  out  1  sticky: write requested while full
- iRdEn  in  1  read request
- oRdData  out  DATA_WIDTH  read data
- oRdValid  out  1  oRdData holds a freshly popped word (FWFT=0) / head word valid (FWFT=1)
- oEmpty  out  1  count == 0
- oAlmostEmpty  out  1  count ≤ AEMPTY_THRESH
- oUnderflow  out  1  sticky: read requested while empty
- oCount  out  CW  occupancy, 0..FIFO_DEPTH

## Operation
- Write accepted: wr_acc = iWrEn & !oFull. Read accepted: rd_acc = iRdEn & !oEmpty. Flags sampled from registered state before the edge.
- Count: +1 on wr_acc&!rd_acc, −1 on rd_acc&!wr_acc, unchanged otherwise. Count driven only by accepted operations, never by raw requests.
- Simultaneous read+write: when full, read accepted, write rejected (overflow set); when empty, write accepted, read rejected (underflow set); otherwise both accepted, count unchanged.
- Pointers: $clog2(FIFO_DEPTH) bits, wrap naturally from FIFO_DEPTH-1 to 0.
- oFull/oEmpty/oAlmostFull/oAlmostEmpty decoded combinationally from registered count.
- oOverflow set on iWrEn&oFull, oUnderflow set on iRdEn&oEmpty; both held until iClr or reset.
- FWFT=0: on rd_acc, oRdData <= mem[rd_ptr], oRdValid=1 next cycle, else oRdValid=0; oRdData holds last value.
- FWFT=1: oRdData = mem[rd_ptr] combinationally, oRdValid = !oEmpty; iRdEn acknowledges/pops the shown word.
- iClr: priority over all writes/reads that cycle; pointers, count, sticky flags, oRdValid -> 0; memory contents and oRdData untouched.

## Timing
- Reset values: oCount=0, oEmpty=1, oAlmostEmpty=1, oFull=0, oAlmostFull=0 (AFULL_THRESH>0), oOverflow=0, oUnderflow=0, oRdValid=0, oRdData=0.
- Write-to-flag latency: 1 cycle (oEmpty falls the cycle after the first accepted write edge).
- Read latency FWFT=0: data and oRdValid 1 cycle after rd_acc edge. FWFT=1: 0 cycles, head visible once oEmpty=0.
- Reset mid-operation: all state to reset values immediately, regardless of clock; in-flight read is lost.
- No combinational path from iWrEn/iRdEn to any output except the FWFT=1 data path (pointer-driven only).

## Structure
- Shared package/header: threshold legality check, CW derivation, FWFT mode constants.
- One sub-module: sync_fifo_mem (DATA_WIDTH×FIFO_DEPTH, one write port, sync or async read selected by FWFT) so it can map to EBR or LUT RAM.
- Control (pointers, count, flags) stays in the top module.

## Test plan
- Reset, write 0x01..0x10 into depth 16 -> oFull=1, oCount=16, oAlmostFull from count 14; read all with FWFT=0 -> 0x01..0x10 in order, each with oRdValid one cycle after iRdEn.
- Write while full (0xAA) -> oOverflow=1 and sticky, count stays 16, 0xAA never read back.
- Read on empty -> oUnderflow=1, oRdValid=0, oCount=0; iClr -> both flags 0.
- Half full (8 words), assert iWrEn&iRdEn for 20 cycles -> oCount stays 8, pointers wrap, data order preserved.
- FWFT=1: single write 0x5C -> oRdData=0x5C, oRdValid=1 one cycle later without iRdEn; pop -> oEmpty=1.
- Assert iRstN low mid-stream at count 5 -> all outputs to reset values asynchronously; iClr with simultaneous iWrEn -> count 0, write dropped.
